// File: rtl/fp16_mul_stream_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// fp16_mul_stream_ctrl
//
// Valid/ready shell around an external fixed-latency, non-stallable fp16
// multiplier. Operand pairs are admitted against a credit count covering both
// in-flight products and buffered results. A LATENCY-deep tag line marks the
// cycle each product emerges. Every product is classified and captured in a
// DEPTH-entry result FIFO. Because of the credit count, a result is never
// dropped under downstream backpressure.
//
// Ports
//   clk, rst_n           clock, synchronous active-low reset
//   in_valid/in_ready    operand handshake; in_ready = outstanding < DEPTH
//   in_a, in_b           fp16 operands
//   mul_a, mul_b         operands to the multiplier (combinational pass-through)
//   mul_out              multiplier result, valid LATENCY edges after issue
//   out_valid/out_ready  result handshake, driven from the FIFO head
//   out_data, out_flags  head result and {nan, inf, zero, subnormal}; 0 when empty
//   level                FIFO occupancy
//   busy                 any product in flight or buffered
// -----------------------------------------------------------------------------
module fp16_mul_stream_ctrl #(
   parameter int LATENCY = 5,
   parameter int DEPTH   = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [15:0]            in_a,
   input  logic [15:0]            in_b,
   output logic [15:0]            mul_a,
   output logic [15:0]            mul_b,
   input  logic [15:0]            mul_out,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [15:0]            out_data,
   output logic [3:0]             out_flags,
   output logic [$clog2(DEPTH):0] level,
   output logic                   busy
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

   // {nan, inf, zero, subnormal}; all clear for a normal number
   function automatic logic [3:0] fp16_flags(input logic [15:0] v);
      logic exp_max;
      logic exp_zero;
      logic frac_zero;
      exp_max   = (v[14:10] == 5'h1f);
      exp_zero  = (v[14:10] == 5'h00);
      frac_zero = (v[9:0] == 10'h000);
      return {exp_max & ~frac_zero, exp_max & frac_zero,
              exp_zero & frac_zero, exp_zero & ~frac_zero};
   endfunction

   logic [LATENCY-1:0] r_tag;
   logic [19:0]        r_mem [DEPTH];
   logic [AW-1:0]      r_wr_ptr;
   logic [AW-1:0]      r_rd_ptr;
   logic [LW-1:0]      r_level;
   logic [LW-1:0]      r_outstanding;

   logic               w_accept;
   logic               w_pop;
   logic               w_mul_wr;
   logic [LATENCY:0]   w_tag_in;
   logic [19:0]        w_head;

   assign mul_a     = in_a;
   assign mul_b     = in_b;

   // Admission looks only at registered credit state, so in_ready never
   // depends on in_valid.
   assign in_ready  = (r_outstanding < DEPTH_L);
   assign w_accept  = in_valid & in_ready;

   assign out_valid = (r_level != '0);
   assign w_pop     = out_valid & out_ready;

   // The oldest tag bit lines up with the matching product on mul_out.
   assign w_mul_wr  = r_tag[LATENCY-1];
   assign w_tag_in  = {r_tag, w_accept};

   // Fall-through head; zeroed when empty so stale entries never show.
   assign w_head    = r_mem[r_rd_ptr];
   assign out_data  = out_valid ? w_head[15:0]  : 16'h0000;
   assign out_flags = out_valid ? w_head[19:16] : 4'h0;

   assign level     = r_level;
   assign busy      = (r_outstanding != '0);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_tag         <= '0;
         r_wr_ptr      <= '0;
         r_rd_ptr      <= '0;
         r_level       <= '0;
         r_outstanding <= '0;
      end else begin
         r_tag <= w_tag_in[LATENCY-1:0];

         if (w_mul_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)    r_rd_ptr <= r_rd_ptr + AW'(1);

         // Simultaneous write and pop leave the level unchanged at any level.
         case ({w_mul_wr, w_pop})
            2'b10:   r_level <= r_level + LW'(1);
            2'b01:   r_level <= r_level - LW'(1);
            default: ;
         endcase

         // Credits cover in-flight products plus buffered results.
         case ({w_accept, w_pop})
            2'b10:   r_outstanding <= r_outstanding + LW'(1);
            2'b01:   r_outstanding <= r_outstanding - LW'(1);
            default: ;
         endcase
      end
   end

   // NOTE: the result array has no reset. Clearing the pointers and level is
   // enough to discard its contents, and the head is masked while empty.
   always_ff @(posedge clk) begin
      if (w_mul_wr) r_mem[r_wr_ptr] <= {fp16_flags(mul_out), mul_out};
   end

   // The credit count must make a write into a full FIFO impossible.
   a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
      w_mul_wr |-> (r_level != DEPTH_L));

endmodule

// File: tb/tb_fp16_mul_stream_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_fp16_mul_stream_ctrl
//
// Self-checking bench for fp16_mul_stream_ctrl. A stand-in multiplier
// (fixed-latency pipe of a lookup/scramble function) drives mul_out. A
// queue-based behavioural model of admission, products in flight and buffered
// results predicts every output on every cycle. Directed scenarios pin the
// model with literal expectations. A long random valid/ready phase follows.
// -----------------------------------------------------------------------------
module tb_fp16_mul_stream_ctrl;

   localparam int LATENCY = 5;
   localparam int DEPTH   = 8;
   localparam int LW      = $clog2(DEPTH) + 1;
   localparam int NPAIRS  = 10000;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [15:0]   in_a = 16'h0000;
   logic [15:0]   in_b = 16'h0000;
   logic [15:0]   mul_a;
   logic [15:0]   mul_b;
   logic [15:0]   mul_out;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [15:0]   out_data;
   logic [3:0]    out_flags;
   logic [LW-1:0] level;
   logic          busy;

   always #5 clk = ~clk;

   fp16_mul_stream_ctrl #(.LATENCY(LATENCY), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .mul_a     (mul_a),
      .mul_b     (mul_b),
      .mul_out   (mul_out),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_flags (out_flags),
      .level     (level),
      .busy      (busy)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Stand-in multiplier function: known products for the directed operands,
   // otherwise a deterministic scramble (b == 0 passes a through unchanged).
   function automatic logic [15:0] mul_model(input logic [15:0] a, input logic [15:0] b);
      case ({a, b})
         32'h3C00_4000: return 16'h4000;
         32'h3C00_3C00: return 16'h3C00;
         32'h7C00_0000: return 16'h7E00;
         32'h0000_BC00: return 16'h8000;
         32'h0400_0400: return 16'h0000;
         default:       return a ^ {b[6:0], b[15:7]};
      endcase
   endfunction

   // Classification from the fp16 field rules.
   function automatic logic [3:0] classify(input logic [15:0] v);
      int e;
      int f;
      e = int'(v[14:10]);
      f = int'(v[9:0]);
      if (e == 31) return (f != 0) ? 4'b1000 : 4'b0100;
      if (e == 0)  return (f != 0) ? 4'b0001 : 4'b0010;
      return 4'b0000;
   endfunction

   // Stand-in multiplier: no reset, fixed latency, never stalls.
   logic [15:0] pipe [LATENCY];
   initial foreach (pipe[i]) pipe[i] = 16'h0000;
   always @(posedge clk) begin
      pipe[0] <= mul_model(mul_a, mul_b);
      for (int i = 1; i < LATENCY; i++) pipe[i] <= pipe[i-1];
   end
   assign mul_out = pipe[LATENCY-1];

   // Behavioural model: products in flight count down LATENCY edges and then
   // join the result queue. Admission is allowed while in-flight + buffered < DEPTH.
   typedef struct {
      int          cnt;
      logic [15:0] data;
   } flight_t;

   flight_t     m_flight[$];
   logic [15:0] m_fifo[$];
   bit          chk_en = 1'b0;

   always @(posedge clk) begin
      bit      acc;
      bit      pop;
      flight_t tmp;
      if (!rst_n) begin
         m_flight.delete();
         m_fifo.delete();
      end else begin
         acc = in_valid && ((m_flight.size() + m_fifo.size()) < DEPTH);
         pop = (m_fifo.size() != 0) && out_ready;
         if (pop) void'(m_fifo.pop_front());
         foreach (m_flight[i]) m_flight[i].cnt = m_flight[i].cnt - 1;
         while (m_flight.size() != 0 && m_flight[0].cnt == 0) begin
            tmp = m_flight.pop_front();
            m_fifo.push_back(tmp.data);
         end
         if (acc) begin
            tmp.cnt  = LATENCY;
            tmp.data = mul_model(in_a, in_b);
            m_flight.push_back(tmp);
         end
      end
   end

   // Compare every output against the model once per cycle, away from the edge.
   always @(negedge clk) begin
      int outst;
      bit have;
      if (chk_en) begin
         outst = m_flight.size() + m_fifo.size();
         have  = (m_fifo.size() != 0);
         check("in_ready",  32'(in_ready),  32'(outst < DEPTH));
         check("out_valid", 32'(out_valid), 32'(have));
         check("level",     32'(level),     32'(m_fifo.size()));
         check("busy",      32'(busy),      32'(outst != 0));
         check("out_data",  32'(out_data),  32'(have ? m_fifo[0] : 16'h0000));
         check("out_flags", 32'(out_flags), 32'(have ? classify(m_fifo[0]) : 4'h0));
         check("mul_a",     32'(mul_a),     32'(in_a));
         check("mul_b",     32'(mul_b),     32'(in_b));
         check("level_le_depth", 32'(32'(level) <= DEPTH), 32'd1);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [15:0] rand_a();
      logic [15:0] specials [8];
      specials = '{16'h7C00, 16'hFC00, 16'h0000, 16'h8000,
                   16'h7E01, 16'h0001, 16'h83FF, 16'h3C00};
      if ($urandom_range(0, 99) < 30) return specials[$urandom_range(0, 7)];
      return 16'($urandom);
   endfunction

   function automatic logic [15:0] rand_b();
      if ($urandom_range(0, 99) < 25) return 16'h0000;
      return 16'($urandom);
   endfunction

   // Directed operand tables
   logic [15:0] t2_a [4] = '{16'h3C00, 16'h7C00, 16'h0000, 16'h0400};
   logic [15:0] t2_b [4] = '{16'h3C00, 16'h0000, 16'hBC00, 16'h0400};
   logic [15:0] t2_d [4] = '{16'h3C00, 16'h7E00, 16'h8000, 16'h0000};
   logic [3:0]  t2_f [4] = '{4'h0, 4'h8, 4'h2, 4'h2};

   logic [15:0] got_d [8];
   logic [3:0]  got_f [8];
   int          got_c [8];
   logic [15:0] exp_d [8];
   int          got_n;

   initial begin
      int first;
      int n_acc;
      int pops;
      int cyc;
      int rdy_pct;

      // ---------------- reset ----------------
      rst_n = 1'b0;
      step();
      step();
      chk_en = 1'b1;
      check("rst_in_ready",  32'(in_ready),  32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_level",     32'(level),     32'd0);
      check("rst_busy",      32'(busy),      32'd0);
      check("rst_out_data",  32'(out_data),  32'd0);
      check("rst_out_flags", 32'(out_flags), 32'd0);
      rst_n = 1'b1;

      // ---------------- single pair latency ----------------
      in_valid = 1'b1; in_a = 16'h3C00; in_b = 16'h4000;
      step();
      in_valid = 1'b0;
      first = -1;
      for (int c = 1; c <= 20; c++) begin
         if (out_valid && first < 0) begin
            first = c;
            got_d[0] = out_data;
            got_f[0] = out_flags;
         end
         step();
      end
      check("t1_latency", 32'(first), 32'd6);
      check("t1_data",    32'(got_d[0]), 32'h4000);
      check("t1_flags",   32'(got_f[0]), 32'h0);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;

      // ---------------- back-to-back, no bubbles ----------------
      out_ready = 1'b1;
      got_n = 0;
      for (int c = 0; c < 30; c++) begin
         if (c < 4) begin
            in_valid = 1'b1; in_a = t2_a[c]; in_b = t2_b[c];
         end else begin
            in_valid = 1'b0;
         end
         if (out_valid && got_n < 8) begin
            got_d[got_n] = out_data; got_f[got_n] = out_flags; got_c[got_n] = c;
            got_n++;
         end
         step();
      end
      check("t2_count", 32'(got_n), 32'd4);
      for (int i = 0; i < 4; i++) begin
         check("t2_data",  32'(got_d[i]), 32'(t2_d[i]));
         check("t2_flags", 32'(got_f[i]), 32'(t2_f[i]));
         check("t2_cycle", 32'(got_c[i]), 32'(6 + i));
      end

      // ---------------- stall: exactly DEPTH accepts ----------------
      out_ready = 1'b0;
      n_acc = 0;
      for (int c = 0; c < 12; c++) begin
         in_valid = 1'b1; in_a = 16'h3000 + 16'(c); in_b = 16'h1234;
         if (c >= 8) check("t3_in_ready_low", 32'(in_ready), 32'd0);
         if (in_ready) begin
            exp_d[n_acc] = mul_model(in_a, in_b);
            n_acc++;
         end
         step();
      end
      in_valid = 1'b0;
      check("t3_accepts", 32'(n_acc), 32'd8);
      for (int c = 0; c < 20 && level != LW'(DEPTH); c++) step();
      check("t3_level_full", 32'(level), 32'(DEPTH));
      out_ready = 1'b1;
      got_n = 0;
      for (int c = 0; c < 20; c++) begin
         if (c == 0) check("t3_ready_before_pop", 32'(in_ready), 32'd0);
         if (c == 1) check("t3_ready_after_pop",  32'(in_ready), 32'd1);
         if (out_valid && got_n < 8) begin
            got_d[got_n] = out_data;
            got_n++;
         end
         step();
      end
      check("t3_drained", 32'(got_n), 32'd8);
      for (int i = 0; i < 8; i++) check("t3_order", 32'(got_d[i]), 32'(exp_d[i]));

      // ---------------- level 1 with pop and write together ----------------
      out_ready = 1'b0;
      for (int c = 0; c < 6; c++) begin
         in_valid = (c < 2);
         in_a = 16'h3C00;
         in_b = (c == 0) ? 16'h4000 : 16'h3C00;
         step();
      end
      in_valid = 1'b0;
      check("t4_level_before", 32'(level),    32'd1);
      check("t4_head_before",  32'(out_data), 32'h4000);
      out_ready = 1'b1;
      step();
      check("t4_level_after",  32'(level),    32'd1);
      check("t4_head_after",   32'(out_data), 32'h3C00);
      step();
      check("t4_empty",        32'(level),    32'd0);
      out_ready = 1'b0;

      // ---------------- reset mid-operation ----------------
      for (int c = 0; c < 7; c++) begin
         in_valid = (c < 5);
         in_a = 16'h4400 + 16'(c); in_b = 16'h3C00;
         step();
      end
      in_valid = 1'b0;
      check("t5_level_pre", 32'(level), 32'd2);
      check("t5_busy_pre",  32'(busy),  32'd1);
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      check("t5_level",     32'(level),     32'd0);
      check("t5_out_valid", 32'(out_valid), 32'd0);
      check("t5_busy",      32'(busy),      32'd0);
      check("t5_in_ready",  32'(in_ready),  32'd1);
      out_ready = 1'b1;
      for (int c = 0; c < 8; c++) begin
         check("t5_no_stale", 32'(out_valid), 32'd0);
         step();
      end

      // ---------------- random valid/ready ----------------
      n_acc = 0; pops = 0; cyc = 0; rdy_pct = 70;
      while (n_acc < NPAIRS && cyc < 60000) begin
         if (cyc % 400 == 0) begin
            case ($urandom_range(0, 2))
               0:       rdy_pct = 10;
               1:       rdy_pct = 60;
               default: rdy_pct = 97;
            endcase
         end
         in_valid  = ($urandom_range(0, 99) < 75);
         in_a      = rand_a();
         in_b      = rand_b();
         out_ready = ($urandom_range(0, 99) < rdy_pct);
         if (in_valid && in_ready)   n_acc++;
         if (out_valid && out_ready) pops++;
         step();
         cyc++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int c = 0; c < 100 && busy; c++) begin
         if (out_valid) pops++;
         step();
      end
      check("rand_accepted", 32'(n_acc), 32'(NPAIRS));
      check("rand_drained",  32'(busy),  32'd0);
      check("rand_no_loss",  32'(pops),  32'(n_acc));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
